// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sample-buffer FIFO family.
// Mode selectors for the FWFT parameter and a depth helper (2**aw words).
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, one clock, registered read port that holds its value when re is low.
// Latency: rdata valid 1 cycle after re. Backpressure: none, the caller never reads the address it writes.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset so dout starts at zero; the array stays reset-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/syn_fifo_fwft.sv
// Single-clock FIFO, standard or first-word-fall-through; SYN_FIFO_ERR_FLAG_EN builds sticky over/underflow flags.
// Latency: STD dout 1 cycle after an accepted read; FWFT head on dout 2 edges after a write into empty.
// Backpressure: wen dropped while full, ren dropped while empty; clr overrides both.
module syn_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DLY        = 1,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ren,
    input  logic [ADDR_WIDTH:0]   afull_th,
    input  logic [ADDR_WIDTH:0]   aempty_th,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  full,
    output logic                  alfull,
    output logic                  empty,
    output logic                  alempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] waddr;
    logic [ADDR_WIDTH:0] raddr;
    logic                wr_ok;
    logic                rd_ok;
    logic                ram_re;

    // DLY is accepted for drop-in compatibility with the previous buffer; no delays are modelled.
    if (DLY < 0) begin : g_dly_unused
    end

    assign full    = (count == DEPTH_CNT);
    assign alfull  = (count >= afull_th);
    assign alempty = (count <= aempty_th);
    assign wr_ok   = wen & ~full & ~clr;
    assign rd_ok   = ren & ~empty & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr <= '0;
            raddr <= '0;
            count <= '0;
        end else if (clr) begin
            waddr <= '0;
            raddr <= '0;
            count <= '0;
        end else begin
            if (wr_ok) waddr <= waddr + PTR_ONE;
            if (ram_re) raddr <= raddr + PTR_ONE;
            count <= count + {{ADDR_WIDTH{1'b0}}, wr_ok} - {{ADDR_WIDTH{1'b0}}, rd_ok};
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        logic stage_vld;
        logic ram_nonempty;

        // The RAM read register is the output stage; refill it when empty or being popped.
        assign ram_nonempty = (waddr != raddr);
        assign ram_re       = ram_nonempty & (~stage_vld | rd_ok) & ~clr;
        assign empty        = ~stage_vld;
        assign dout_vld     = stage_vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_vld <= 1'b0;
            end else if (clr) begin
                stage_vld <= 1'b0;
            end else if (ram_re) begin
                stage_vld <= 1'b1;
            end else if (rd_ok) begin
                stage_vld <= 1'b0;
            end
        end
    end else begin : g_std
        logic rd_pulse;

        assign ram_re   = rd_ok;
        assign empty    = (count == '0);
        assign dout_vld = rd_pulse;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_pulse <= 1'b0;
            end else begin
                rd_pulse <= rd_ok;
            end
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (waddr[ADDR_WIDTH-1:0]),
        .wdata (din),
        .re    (ram_re),
        .raddr (raddr[ADDR_WIDTH-1:0]),
        .rdata (dout)
    );

`ifdef SYN_FIFO_ERR_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && full && !clr) overflow <= 1'b1;
            if (ren && empty && !clr) underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
